gpio_port: RTL

- Downstream consumer of the register-map bus: owns one bank of GPIO pins behind a window of the 8-bit address space.
- Decodes bus reads and writes, drives pin direction and output, and synchronises pin inputs.
- Detects per-pin edges and latches them into a write-1-to-clear status register, producing a level interrupt.
- Sits between the register map / main controller and the FPGA pins at top level.

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_sync_edge.sv | 49 ++++
 rtl/gpio_port.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: register offsets within the bus window
// and the per-pin edge-select encoding.
package gpio_pkg;

  localparam logic [2:0] GPIO_DIR      = 3'd0;
  localparam logic [2:0] GPIO_OUT      = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd4;
  localparam logic [2:0] GPIO_EDGE_SEL = 3'd5;
  localparam int         GPIO_NUM_REGS = 6;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  // Window check done in 9 bits so a base near the top of the map cannot wrap.
  function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
    logic [8:0] a9;
    logic [8:0] b9;
    a9 = {1'b0, addr};
    b9 = {1'b0, base};
    return (a9 >= b9) && (a9 < b9 + 9'(GPIO_NUM_REGS));
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with a one-flop history and rise/fall detection,
// gated by a short warm-up after reset so pins held high do not look like edges.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int                CNT_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  WARM_LOAD = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]                  prev_reg;
  logic [CNT_W-1:0]                  warm_reg;
  logic                              warm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= '0;
      prev_reg  <= '0;
      warm_reg  <= WARM_LOAD;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_in};
      prev_reg  <= chain_reg[SYNC_STAGES-1];
      if (warm_reg != '0) begin
        warm_reg <= warm_reg - 1'b1;
      end
    end
  end

  assign sync      = chain_reg[SYNC_STAGES-1];
  assign warm_done = (warm_reg == '0);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign rise[gi] = warm_done &  sync[gi] & ~prev_reg[gi];
      assign fall[gi] = warm_done & ~sync[gi] &  prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/gpio_port.sv
// One bank of GPIO pins behind a six-register bus window: direction, output,
// synchronised input, and edge-triggered W1C status driving a level interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] irq_en_reg;
  logic [WIDTH-1:0] irq_stat_reg;
  logic [WIDTH-1:0] edge_sel_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
  logic             irq_reg;

  logic             hit;
  logic [2:0]       reg_sel;
  logic             wr_hit;
  logic             rd_hit;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_bits;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] irq_stat_next;
  logic [WIDTH-1:0] rd_mux;

  assign hit     = in_window(addr, BASE_ADDR);
  assign reg_sel = 3'(addr - BASE_ADDR);
  assign wr_hit  = wr_en & hit;
  assign rd_hit  = rd_en & hit;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (CLK),
    .rst    (RST),
    .pin_in (pin_in),
    .sync   (sync),
    .rise   (rise),
    .fall   (fall)
  );

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_event
      assign event_bits[gi] = (edge_sel_reg[gi] == EDGE_FALL) ? fall[gi] : rise[gi];
    end
  endgenerate

  // Clearing is applied before the new events are OR-ed in, so a same-cycle set wins.
  assign w1c_mask      = (wr_hit && reg_sel == GPIO_IRQ_STAT) ? wr_data : '0;
  assign irq_stat_next = (irq_stat_reg & ~w1c_mask) | event_bits;

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      GPIO_DIR:      rd_mux = dir_reg;
      GPIO_OUT:      rd_mux = out_reg;
      GPIO_IN:       rd_mux = sync;
      GPIO_IRQ_EN:   rd_mux = irq_en_reg;
      GPIO_IRQ_STAT: rd_mux = irq_stat_reg;
      GPIO_EDGE_SEL: rd_mux = edge_sel_reg;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dir_reg      <= '0;
      out_reg      <= '0;
      irq_en_reg   <= '0;
      irq_stat_reg <= '0;
      edge_sel_reg <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_hit) begin
        case (reg_sel)
          GPIO_DIR:      dir_reg      <= wr_data;
          GPIO_OUT:      out_reg      <= wr_data;
          GPIO_IRQ_EN:   irq_en_reg   <= wr_data;
          GPIO_EDGE_SEL: edge_sel_reg <= wr_data;
          default:       ;
        endcase
      end
      irq_stat_reg <= irq_stat_next;
      // Read mux sees the registers before this edge's write lands.
      rd_valid_reg <= rd_hit;
      if (rd_hit) begin
        rd_data_reg <= rd_mux;
      end
      irq_reg <= |(irq_stat_reg & irq_en_reg);
    end
  end

  assign pin_oe   = dir_reg;
  assign pin_out  = out_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign irq      = irq_reg;

endmodule
